// File: rtl/cos_nco_pkg.sv
// Shared types, default widths and LUT address extraction for the cosine NCO.
// Define COS_LUT_NCO_ROUND_EN to round the LUT address to nearest instead of truncating.
package cos_nco_pkg;

  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_PHASE_WIDTH = 22;
  localparam int DEF_LEN_WIDTH   = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  // pw/aw are elaboration constants at every call site, so shifts reduce to wiring.
  function automatic logic [63:0] phase_to_addr(input logic [63:0] acc,
                                                input int pw, input int aw);
    logic [63:0] mask;
    logic [63:0] addr;
    mask = (64'd1 << aw) - 64'd1;
    addr = (acc >> (pw - aw)) & mask;
`ifdef COS_LUT_NCO_ROUND_EN
    addr = (addr + ((acc >> (pw - aw - 1)) & 64'd1)) & mask;
`else
    addr = addr & mask;
`endif
    return addr;
  endfunction

endpackage

// File: rtl/cos_lut_nco_if.sv
// Configuration, control, LUT read and sample stream signals of cos_lut_nco.
interface cos_lut_nco_if
  import cos_nco_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) ();

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_freq;
  logic [PHASE_WIDTH-1:0] cfg_phase;
  logic [LEN_WIDTH-1:0]   cfg_len;
  logic                   start;
  logic                   stop;
  logic [ADDR_WIDTH-1:0]  lut_rd_addr;
  logic [DATA_WIDTH-1:0]  lut_rd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_valid, cfg_freq, cfg_phase, cfg_len, start, stop, lut_rd_data, out_ready,
    input  cfg_ready, lut_rd_addr, out_valid, out_data, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_freq, cfg_phase, cfg_len, start, stop, lut_rd_data, out_ready,
    output cfg_ready, lut_rd_addr, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/cos_nco_phase_acc.sv
// Phase accumulator: holds frequency/phase configuration and the running phase,
// and derives the LUT read address from the accumulator.
module cos_nco_phase_acc
  import cos_nco_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [PHASE_WIDTH-1:0] cfg_freq,
  input  logic [PHASE_WIDTH-1:0] cfg_phase,
  input  logic                   load,
  input  logic                   advance,
  output logic [ADDR_WIDTH-1:0]  lut_rd_addr
);

  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] freq_r;
  logic [PHASE_WIDTH-1:0] phase_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      freq_r  <= '0;
      phase_r <= '0;
    end else begin
      if (cfg_load) begin
        freq_r  <= cfg_freq;
        phase_r <= cfg_phase;
      end
      // The phase wraps naturally modulo 2**PHASE_WIDTH.
      if (load)
        acc <= phase_r;
      else if (advance)
        acc <= acc + freq_r;
    end
  end

  assign lut_rd_addr = ADDR_WIDTH'(phase_to_addr(64'(acc), PHASE_WIDTH, ADDR_WIDTH));

endmodule

// File: rtl/cos_lut_nco.sv
// Burst reader of the cosine LUT: walks the LUT with a phase accumulator and
// streams one sample per accepted transfer. Optional macro: COS_LUT_NCO_ROUND_EN.
module cos_lut_nco
  import cos_nco_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input logic         clk,
  input logic         rst,
  cos_lut_nco_if.slave bus
);

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  done;

  logic cfg_load;
  logic start_go;
  logic issue;
  logic last;

  assign cfg_load = bus.cfg_valid && (state == IDLE);
  assign start_go = (state == IDLE) && bus.start && !bus.stop;
  assign issue    = (state == RUN) && (!out_valid || bus.out_ready) && !bus.stop;
  // len_r == 0 is continuous mode: count wraps and never terminates the burst.
  assign last     = (len_r != '0) && (count == len_r - LEN_WIDTH'(1));

  cos_nco_phase_acc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_phase_acc (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_freq    (bus.cfg_freq),
    .cfg_phase   (bus.cfg_phase),
    .load        (start_go),
    .advance     (issue),
    .lut_rd_addr (bus.lut_rd_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_load)
        len_r <= bus.cfg_len;

      case (state)
        IDLE: begin
          if (start_go) begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (issue && last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A pending sample survives a stop and drains even from IDLE.
      if (issue) begin
        out_data  <= bus.lut_rd_data;
        out_valid <= 1'b1;
        count     <= count + LEN_WIDTH'(1);
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.done      = done;

endmodule
